// File: rtl/feeder_pkg.sv
// Shared types and sizing helpers for the multi-channel pet feeder controller.
package feeder_pkg;

  typedef enum logic [2:0] {IDLE, WAIT, PEND, DISP, FAULT} feed_state_e;

  localparam int FEED_W      = 8;
  localparam int SEC_PER_MIN = 60;
  localparam int MIN_CNT_W   = $clog2(SEC_PER_MIN);

  // Counter/index width that never collapses to zero bits.
  function automatic int bits_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/feeder_chan.sv
// One feeding channel: interval store, minute countdown, dispense FSM,
// dispense timeout and saturating feed counter.
module feeder_chan
  import feeder_pkg::*;
#(
  parameter int MIN_W  = 8,
  parameter int TO_SEC = 30
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              sensor_i,
  input  logic              set_we_i,
  input  logic [MIN_W-1:0]  set_min_i,
  input  logic              clr_fault_i,
  input  logic              sec_tick_i,
  input  logic              min_tick_i,
  input  logic              grant_i,
  output logic              pend_o,
  output logic              motor_o,
  output logic              fault_o,
  output logic [MIN_W-1:0]  remain_o,
  output logic [FEED_W-1:0] feed_cnt_o
);

  localparam int TO_W = bits_for(TO_SEC);

  feed_state_e       state_q, state_d;
  logic [MIN_W-1:0]  remain_q, remain_d;
  logic [MIN_W-1:0]  interval_q, interval_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [FEED_W-1:0] feed_q, feed_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      remain_q   <= '0;
      interval_q <= MIN_W'(1);
      to_cnt_q   <= '0;
      feed_q     <= '0;
    end else begin
      state_q    <= state_d;
      remain_q   <= remain_d;
      interval_q <= interval_d;
      to_cnt_q   <= to_cnt_d;
      feed_q     <= feed_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    remain_d   = remain_q;
    interval_d = interval_q;
    to_cnt_d   = to_cnt_q;
    feed_d     = feed_q;
    // A zero interval would never expire, so it is promoted to one minute.
    if (set_we_i) interval_d = (set_min_i == '0) ? MIN_W'(1) : set_min_i;
    if (!enable_i && state_q != FAULT) begin
      state_d  = IDLE;
      remain_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          remain_d = interval_q;
          state_d  = WAIT;
        end
        WAIT: if (min_tick_i) begin
          if (remain_q <= MIN_W'(1)) begin
            remain_d = '0;
            state_d  = PEND;
          end else begin
            remain_d = remain_q - MIN_W'(1);
          end
        end
        PEND: begin
          // Bowl already full: skip this feed and start the next interval.
          if (sensor_i) begin
            remain_d = interval_q;
            state_d  = WAIT;
          end else if (grant_i) begin
            to_cnt_d = '0;
            state_d  = DISP;
          end
        end
        DISP: begin
          if (sensor_i) begin
            feed_d   = (feed_q == '1) ? feed_q : feed_q + FEED_W'(1);
            remain_d = interval_q;
            state_d  = WAIT;
          end else if (sec_tick_i) begin
            if (to_cnt_q == TO_W'(TO_SEC - 1)) state_d = FAULT;
            else to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
        FAULT: if (clr_fault_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign pend_o     = (state_q == PEND);
  assign motor_o    = (state_q == DISP);
  assign fault_o    = (state_q == FAULT);
  assign remain_o   = remain_q;
  assign feed_cnt_o = feed_q;

endmodule

// File: rtl/multi_feeder_ctrl.sv
// Multi-channel feeder: shared second/minute prescaler, single-motor arbiter
// and remaining-time view mux around NCH feeder_chan instances.
module multi_feeder_ctrl
  import feeder_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int MIN_W      = 8,
  parameter int SEC_CYCLES = 50_000_000,
  parameter int TO_SEC     = 30
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NCH-1:0]           enable,
  input  logic [NCH-1:0]           sensor,
  input  logic                     set_valid,
  input  logic [bits_for(NCH)-1:0] set_ch,
  input  logic [MIN_W-1:0]         set_min,
  input  logic [NCH-1:0]           clr_fault,
  input  logic [bits_for(NCH)-1:0] view_ch,
  output logic [NCH-1:0]           motor,
  output logic [NCH-1:0]           fault,
  output logic [MIN_W-1:0]         remain_min,
  output logic [FEED_W*NCH-1:0]    feed_cnt
);

  localparam int CH_W  = bits_for(NCH);
  localparam int SEC_W = bits_for(SEC_CYCLES);

  logic [SEC_W-1:0]     sec_cnt_q, sec_cnt_d;
  logic [MIN_CNT_W-1:0] min_cnt_q, min_cnt_d;
  logic                 sec_tick, min_tick;
  logic [NCH-1:0]       pend, grant;
  logic [MIN_W-1:0]     remain [NCH];

  assign sec_tick = (sec_cnt_q == SEC_W'(SEC_CYCLES - 1));
  assign min_tick = sec_tick && (min_cnt_q == MIN_CNT_W'(SEC_PER_MIN - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      sec_cnt_q <= '0;
      min_cnt_q <= '0;
    end else begin
      sec_cnt_q <= sec_cnt_d;
      min_cnt_q <= min_cnt_d;
    end
  end

  always_comb begin
    sec_cnt_d = sec_tick ? '0 : sec_cnt_q + SEC_W'(1);
    min_cnt_d = min_cnt_q;
    if (sec_tick) min_cnt_d = min_tick ? '0 : min_cnt_q + MIN_CNT_W'(1);
  end

  // Lowest pending channel wins, and only while the motor bus is free.
  assign grant = (|motor) ? '0 : (pend & (~pend + NCH'(1)));

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    feeder_chan #(
      .MIN_W  (MIN_W),
      .TO_SEC (TO_SEC)
    ) u_chan (
      .clk_i       (clk),
      .rst_ni      (reset),
      .enable_i    (enable[g]),
      .sensor_i    (sensor[g]),
      .set_we_i    (set_valid && (set_ch == CH_W'(g))),
      .set_min_i   (set_min),
      .clr_fault_i (clr_fault[g]),
      .sec_tick_i  (sec_tick),
      .min_tick_i  (min_tick),
      .grant_i     (grant[g]),
      .pend_o      (pend[g]),
      .motor_o     (motor[g]),
      .fault_o     (fault[g]),
      .remain_o    (remain[g]),
      .feed_cnt_o  (feed_cnt[FEED_W*g +: FEED_W])
    );
  end

  always_comb begin
    remain_min = '0;
    for (int i = 0; i < NCH; i++)
      if (view_ch == CH_W'(i)) remain_min = remain[i];
  end

endmodule

// File: tb/tb_multi_feeder_ctrl.sv
// Randomised and directed bench for multi_feeder_ctrl against a rule-level
// reference model driven by absolute time since reset.
module tb_multi_feeder_ctrl;

  localparam int NCH        = 2;
  localparam int MIN_W      = 8;
  localparam int SEC_CYCLES = 2;
  localparam int TO_SEC     = 3;
  localparam int MIN_CYC    = SEC_CYCLES * 60;

  localparam int P_IDLE = 0, P_WAIT = 1, P_PEND = 2, P_DISP = 3, P_FAULT = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [NCH-1:0]   enable, sensor, clr_fault;
  logic             set_valid;
  logic [0:0]       set_ch, view_ch;
  logic [MIN_W-1:0] set_min;
  logic [NCH-1:0]   motor, fault;
  logic [MIN_W-1:0] remain_min;
  logic [8*NCH-1:0] feed_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  int m_t;
  int m_ph [NCH];
  int m_rem [NCH];
  int m_ival [NCH];
  int m_fc [NCH];
  int m_secs [NCH];

  always #5 clk = ~clk;

  multi_feeder_ctrl #(
    .NCH(NCH), .MIN_W(MIN_W), .SEC_CYCLES(SEC_CYCLES), .TO_SEC(TO_SEC)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .sensor(sensor),
    .set_valid(set_valid), .set_ch(set_ch), .set_min(set_min),
    .clr_fault(clr_fault), .view_ch(view_ch), .motor(motor), .fault(fault),
    .remain_min(remain_min), .feed_cnt(feed_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Rule-level model: ticks derive from elapsed cycles since reset.
  task automatic model_step();
    bit sec, mnt, busy;
    int win;
    if (!reset) begin
      m_t = 0;
      for (int i = 0; i < NCH; i++) begin
        m_ph[i] = P_IDLE; m_rem[i] = 0; m_ival[i] = 1; m_fc[i] = 0; m_secs[i] = 0;
      end
      return;
    end
    sec  = (m_t % SEC_CYCLES) == SEC_CYCLES - 1;
    mnt  = (m_t % MIN_CYC) == MIN_CYC - 1;
    busy = 1'b0;
    win  = -1;
    for (int i = 0; i < NCH; i++) if (m_ph[i] == P_DISP) busy = 1'b1;
    if (!busy)
      for (int i = NCH - 1; i >= 0; i--) if (m_ph[i] == P_PEND) win = i;
    for (int i = 0; i < NCH; i++) begin
      if (m_ph[i] != P_FAULT && !enable[i]) begin
        m_ph[i] = P_IDLE; m_rem[i] = 0;
      end else if (m_ph[i] == P_IDLE) begin
        m_ph[i] = P_WAIT; m_rem[i] = m_ival[i];
      end else if (m_ph[i] == P_WAIT) begin
        if (mnt) begin
          m_rem[i]--;
          if (m_rem[i] <= 0) begin m_rem[i] = 0; m_ph[i] = P_PEND; end
        end
      end else if (m_ph[i] == P_PEND) begin
        if (sensor[i]) begin m_ph[i] = P_WAIT; m_rem[i] = m_ival[i]; end
        else if (win == i) begin m_ph[i] = P_DISP; m_secs[i] = 0; end
      end else if (m_ph[i] == P_DISP) begin
        if (sensor[i]) begin
          m_ph[i] = P_WAIT; m_rem[i] = m_ival[i];
          if (m_fc[i] < 255) m_fc[i]++;
        end else if (sec) begin
          m_secs[i]++;
          if (m_secs[i] >= TO_SEC) m_ph[i] = P_FAULT;
        end
      end else if (clr_fault[i]) begin
        m_ph[i] = P_IDLE;
      end
    end
    if (set_valid && int'(set_ch) < NCH)
      m_ival[set_ch] = (set_min == 0) ? 1 : int'(set_min);
    m_t++;
  endtask

  task automatic compare();
    logic [NCH-1:0]   em, ef;
    logic [8*NCH-1:0] ec;
    for (int i = 0; i < NCH; i++) begin
      em[i] = (m_ph[i] == P_DISP);
      ef[i] = (m_ph[i] == P_FAULT);
      ec[8*i +: 8] = 8'(m_fc[i]);
    end
    chk("motor", 32'(motor), 32'(em));
    chk("fault", 32'(fault), 32'(ef));
    chk("remain_min", 32'(remain_min), 32'(m_rem[view_ch]));
    chk("feed_cnt", 32'(feed_cnt), 32'(ec));
    chk("motor_onehot", 32'($countones(motor) <= 1), 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    reset = 1'b0; enable = '0; sensor = '0; clr_fault = '0;
    set_valid = 1'b0; set_ch = '0; set_min = '0; view_ch = '0;
    repeat (3) tick();
    reset = 1'b1;
  endtask

  task automatic wait_motor(input int ch, input int budget, output bit ok, output int cyc);
    ok = 1'b0; cyc = 0;
    while (cyc < budget && !motor[ch]) begin tick(); cyc++; end
    ok = motor[ch];
  endtask

  task automatic set_iv(input int ch, input int mins);
    set_valid = 1'b1; set_ch = 1'(ch); set_min = MIN_W'(mins);
    tick();
    set_valid = 1'b0;
  endtask

  initial begin
    bit ok;
    int cyc;

    // Reset state
    do_reset();
    chk("rst_motor", 32'(motor), 32'd0);
    chk("rst_feed", 32'(feed_cnt), 32'd0);

    // Single channel, 2-minute interval, sensor confirms the feed
    set_iv(0, 2);
    enable[0] = 1'b1;
    wait_motor(0, 400, ok, cyc);
    chk("ch0_motor_rise", 32'(ok), 32'd1);
    chk("ch0_rise_window", 32'(cyc >= 230 && cyc <= 250), 32'd1);
    sensor[0] = 1'b1;
    tick();
    sensor[0] = 1'b0;
    chk("ch0_motor_drop", 32'(motor[0]), 32'd0);
    chk("ch0_feed1", 32'(feed_cnt[7:0]), 32'd1);
    repeat (4) tick();

    // Simultaneous expiry: ch0 first, ch1 after ch0 leaves DISP
    do_reset();
    set_iv(0, 1);
    set_iv(1, 1);
    enable = 2'b11;
    wait_motor(0, 300, ok, cyc);
    chk("arb_ch0_first", 32'(ok), 32'd1);
    chk("arb_ch1_held", 32'(motor[1]), 32'd0);
    repeat (2) tick();
    chk("arb_ch1_still_held", 32'(motor[1]), 32'd0);
    sensor[0] = 1'b1;
    tick();
    sensor[0] = 1'b0;
    wait_motor(1, 5, ok, cyc);
    chk("arb_ch1_granted", 32'(ok), 32'd1);
    sensor[1] = 1'b1;
    tick();
    sensor[1] = 1'b0;
    repeat (3) tick();

    // Dispense timeout, then fault clear back through IDLE to WAIT
    do_reset();
    enable[1] = 1'b1;
    view_ch = 1'b1;
    wait_motor(1, 300, ok, cyc);
    chk("to_motor_rise", 32'(ok), 32'd1);
    cyc = 0;
    while (cyc < 12 && !fault[1]) begin tick(); cyc++; end
    chk("to_fault_set", 32'(fault[1]), 32'd1);
    chk("to_window", 32'(cyc >= 4 && cyc <= 7), 32'd1);
    chk("to_motor_off", 32'(motor[1]), 32'd0);
    repeat (5) tick();
    chk("to_fault_sticky", 32'(fault[1]), 32'd1);
    clr_fault[1] = 1'b1;
    tick();
    clr_fault[1] = 1'b0;
    chk("to_fault_clr", 32'(fault[1]), 32'd0);
    tick();
    chk("to_rewait_remain", 32'(remain_min), 32'd1);

    // Reset asserted mid-dispense
    do_reset();
    set_iv(0, 3);
    enable[0] = 1'b1;
    view_ch = 1'b0;
    wait_motor(0, 500, ok, cyc);
    chk("mid_motor_rise", 32'(ok), 32'd1);
    reset = 1'b0;
    tick();
    chk("mid_rst_motor", 32'(motor), 32'd0);
    chk("mid_rst_feed", 32'(feed_cnt), 32'd0);
    chk("mid_rst_remain", 32'(remain_min), 32'd0);
    reset = 1'b1;
    enable = '0;
    tick();

    // Zero interval stored as one minute; feed counter saturates at 255
    do_reset();
    set_iv(0, 0);
    enable[0] = 1'b1;
    tick();
    chk("min0_stored", 32'(remain_min), 32'd1);
    for (int k = 0; k < 258 * MIN_CYC; k++) begin
      sensor[0] = motor[0];
      tick();
    end
    sensor[0] = 1'b0;
    chk("feed_saturate", 32'(feed_cnt[7:0]), 32'd255);

    // Randomised traffic
    do_reset();
    enable = 2'b11;
    for (int k = 0; k < 15000; k++) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 199) == 0) enable[i] = ~enable[i];
        sensor[i] = motor[i] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
        clr_fault[i] = ($urandom_range(0, 19) == 0);
      end
      set_valid = ($urandom_range(0, 49) == 0);
      set_ch    = 1'($urandom_range(0, 1));
      set_min   = MIN_W'($urandom_range(0, 3));
      view_ch   = 1'($urandom_range(0, 1));
      reset     = ($urandom_range(0, 2999) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_feeder_ctrl.md
MULTI_FEEDER_CTRL -- requirements
Module: multi_feeder_ctrl

Interface
REQ-001 Parameter NCH, default 2: number of independent feeding channels (1..8).
REQ-002 Parameter MIN_W, default 8: width of the interval and remaining-time fields, in minutes.
REQ-003 Parameter SEC_CYCLES, default 50_000_000: clk cycles per second tick.
REQ-004 Parameter TO_SEC, default 30: dispense timeout, in seconds.
REQ-005 Port clk, input, 1: single system clock; all logic rising-edge.
REQ-006 Port reset, input, 1: synchronous, active-low reset.
REQ-007 Port enable, input, NCH: per-channel auto mode; 0 = channel held idle.
REQ-008 Port sensor, input, NCH: per-channel bowl-full sensor, active-high, already synchronised.
REQ-009 Port set_valid, input, 1: one-cycle write strobe for an interval.
REQ-010 Port set_ch, input, clog2(NCH): channel addressed by set_valid.
REQ-011 Port set_min, input, MIN_W: interval to store, in minutes.
REQ-012 Port clr_fault, input, NCH: per-channel fault clear, level.
REQ-013 Port view_ch, input, clog2(NCH): channel shown on remain_min.
REQ-014 Port motor, output, NCH: per-channel motor drive, active-high.
REQ-015 Port fault, output, NCH: per-channel timeout fault flag.
REQ-016 Port remain_min, output, MIN_W: remaining minutes of view_ch, combinational from registers.
REQ-017 Port feed_cnt, output, 8*NCH: per-channel saturating count of completed feeds.

Function
REQ-018 Shared prescaler: sec_tick is high for one cycle every SEC_CYCLES cycles; a 0..59 counter of sec_tick produces min_tick on the wrap from 59 to 0.
REQ-019 set_valid stores set_min into interval[set_ch] on the same edge; a set_min of 0 is stored as 1.
REQ-020 Each channel runs one FSM with states IDLE, WAIT, PEND, DISP and FAULT.
REQ-021 IDLE: when enable=1, the channel loads remain=interval and moves to WAIT.
REQ-022 WAIT: remain decrements on each min_tick; on the min_tick where remain=1, remain becomes 0 and the channel moves to PEND.
REQ-023 PEND: the channel waits for the motor grant. The grant goes to the lowest-index PEND channel, and only when no channel is in DISP; at most one motor bit is ever high.
REQ-024 DISP: motor=1 and a per-channel second counter clears on entry.
REQ-025 DISP exit, sensor=1: the motor drops on the next edge, feed_cnt increments (saturating at 255), remain reloads and the channel moves to WAIT.
REQ-026 DISP exit, timeout: when TO_SEC sec_ticks elapse without sensor=1, motor=0, fault=1 and the channel moves to FAULT.
REQ-027 FAULT: motor stays 0. clr_fault=1 moves the channel to IDLE and clears fault; the fault otherwise persists.
REQ-028 enable=0 in any state except FAULT forces IDLE within one cycle, with motor=0 and remain=0.
REQ-029 If PEND is entered while sensor=1, the channel skips the feed: it reloads remain, returns to WAIT and does not increment feed_cnt.
REQ-030 A set_valid to a channel in WAIT does not change its running remain; the new interval applies from the next reload.
REQ-031 If sec_tick and min_tick coincide with a state exit, the exiting state's rule wins and the tick is not carried into the next state.
REQ-032 remain_min outputs remain[view_ch]; a view_ch value at or above NCH outputs 0.

Reset
REQ-033 While reset=0 at a clock edge, every channel goes to IDLE and the outputs read motor=0, fault=0, remain_min=0 and feed_cnt=0.
REQ-034 Reset also clears both prescalers and sets every interval to 1.
REQ-035 Reset mid-DISP drops the motor on that same edge.

Structure
REQ-036 A shared package feeder_pkg holds the state enum (IDLE, WAIT, PEND, DISP, FAULT) and the clog2-derived width constants.
REQ-037 The per-channel FSM, remain register and counters are one sub-module, feeder_chan, instantiated NCH times; the prescaler, arbiter and view mux stay in the top level.

Verification
REQ-038 Bench parameters: SEC_CYCLES=2 (one minute = 120 cycles), TO_SEC=3 and NCH=2.
REQ-039 Scenario: set ch0 interval=2 and enable[0]=1 -> motor[0] rises about 240 cycles later; sensor[0]=1 then drops motor[0] the next cycle and feed_cnt[7:0]=1.
REQ-040 Scenario: both channels with interval=1 expire on the same min_tick -> motor[0] goes high first; motor[1] rises only after ch0 leaves DISP, and the two motor bits are never high together.
REQ-041 Scenario: sensor held 0 in DISP -> after 3 sec_ticks (6 cycles), motor=0 and fault=1; a clr_fault pulse returns the channel to IDLE, then to WAIT while enable=1.
REQ-042 Scenario: reset=0 asserted mid-DISP -> on the next edge motor=0, feed_cnt=0 and remain_min=0.
REQ-043 Scenario: set_min=0 -> a 1-minute interval is stored; with feed_cnt at 255, a further feed keeps it at 255.
